// File: rtl/pwe_pkg.sv
// Shared types and constants for the pulse-width burst engine.
package pwe_pkg;

  localparam int unsigned DefaultW  = 8;
  localparam int unsigned DefaultNW = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_BURST   = 2'd1;
  localparam logic [1:0] MODE_CONT    = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } pwe_state_t;

endpackage

// File: rtl/pwe_burst_gen_if.sv
// Control and status bundle between the pin mapper (master) and the engine (slave).
interface pwe_burst_gen_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned NW = 4
) ();

  logic          enable;
  logic          start;
  logic          stop;
  logic          abort;
  logic [1:0]    mode;
  logic [W-1:0]  width;
  logic [W-1:0]  gap;
  logic [NW-1:0] count;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [NW-1:0] pulse_cnt;

  modport master (
    output enable, start, stop, abort, mode, width, gap, count,
    input  pulse_out, busy, done, pulse_cnt
  );

  modport slave (
    input  enable, start, stop, abort, mode, width, gap, count,
    output pulse_out, busy, done, pulse_cnt
  );

endinterface

// File: rtl/pwe_cnt.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module pwe_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic [W-1:0] q_o,
  output logic         zero_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = value_i;
    end else if (dec_i && (q_q != '0)) begin
      q_d = q_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == '0);

endmodule

// File: rtl/pwe_burst_gen.sv
// Pulse-width engine: one-shot, burst and continuous pulse trains with stop/abort.
module pwe_burst_gen
  import pwe_pkg::*;
#(
  parameter int unsigned W  = DefaultW,
  parameter int unsigned NW = DefaultNW
) (
  input logic             clk,
  input logic             rst_n,
  pwe_burst_gen_if.slave  bus
);

  pwe_state_t    state_q, state_d;
  logic [1:0]    mode_q;
  logic [W-1:0]  width_q, gap_q;
  logic [NW-1:0] pulse_cnt_q;
  logic          stop_q, stop_d;

  logic          latch, cnt_clr, cnt_inc, stop_seen;
  logic          ph_load, ph_dec, ph_zero;
  logic [W-1:0]  ph_value, ph_q;
  logic          bst_load, bst_dec, bst_zero;
  logic [NW-1:0] bst_value, bst_q;
  logic [W-1:0]  gap_len_m1;
  logic          unused_q;

  // Counter values only matter through their zero flags.
  assign unused_q = ^{ph_q, bst_q};

  // A zero gap still yields one LOW cycle so pulses never merge.
  assign gap_len_m1 = (gap_q == '0) ? '0 : gap_q - W'(1);
  assign stop_seen  = stop_q | bus.stop;

  pwe_cnt #(.W(W)) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ph_load),
    .value_i (ph_value),
    .dec_i   (ph_dec),
    .q_o     (ph_q),
    .zero_o  (ph_zero)
  );

  pwe_cnt #(.W(NW)) u_burst_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (bst_load),
    .value_i (bst_value),
    .dec_i   (bst_dec),
    .q_o     (bst_q),
    .zero_o  (bst_zero)
  );

  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    latch     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ph_load   = 1'b0;
    ph_value  = '0;
    ph_dec    = 1'b0;
    bst_load  = 1'b0;
    bst_value = '0;
    bst_dec   = 1'b0;

    if ((state_q != StIdle) && bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          stop_d = 1'b0;
          if (bus.start && bus.enable && !bus.abort) begin
            latch     = 1'b1;
            cnt_clr   = 1'b1;
            ph_load   = 1'b1;
            ph_value  = bus.width - W'(1);
            bst_load  = 1'b1;
            bst_value = (bus.count == '0) ? '0 : bus.count - NW'(1);
            state_d   = (bus.width == '0) ? StDone : StHigh;
          end
        end
        StHigh: begin
          stop_d = stop_seen;
          if (ph_zero) begin
            cnt_inc = 1'b1;
            if (stop_seen) begin
              state_d = StDone;
            end else begin
              case (mode_q)
                MODE_BURST: begin
                  if (bst_zero) begin
                    state_d = StDone;
                  end else begin
                    bst_dec  = 1'b1;
                    ph_load  = 1'b1;
                    ph_value = gap_len_m1;
                    state_d  = StLow;
                  end
                end
                MODE_CONT: begin
                  ph_load  = 1'b1;
                  ph_value = gap_len_m1;
                  state_d  = StLow;
                end
                default: state_d = StDone;
              endcase
            end
          end else begin
            ph_dec = 1'b1;
          end
        end
        StLow: begin
          stop_d = stop_seen;
          if (stop_seen) begin
            state_d = StDone;
          end else if (ph_zero) begin
            ph_load  = 1'b1;
            ph_value = width_q - W'(1);
            state_d  = StHigh;
          end else begin
            ph_dec = 1'b1;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stop_q      <= 1'b0;
      mode_q      <= MODE_ONESHOT;
      width_q     <= '0;
      gap_q       <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      if (latch) begin
        mode_q  <= bus.mode;
        width_q <= bus.width;
        gap_q   <= bus.gap;
      end
      if (cnt_clr) begin
        pulse_cnt_q <= '0;
      end else if (cnt_inc) begin
        pulse_cnt_q <= pulse_cnt_q + NW'(1);
      end
    end
  end

  assign bus.pulse_out = (state_q == StHigh);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pwe_burst_gen.sv
// Directed bench for pwe_burst_gen; traces are bit vectors, bit i = cycle t+1+i after accept.
module tb_pwe_burst_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwe_burst_gen_if #(.W(8), .NW(4)) bus ();
  pwe_burst_gen_if #(.W(8), .NW(2)) bus2 ();

  pwe_burst_gen #(.W(8), .NW(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pwe_burst_gen #(.W(8), .NW(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] w, input logic [7:0] g,
                       input logic [3:0] c);
    bus.mode  = m;
    bus.width = w;
    bus.gap   = g;
    bus.count = c;
  endtask

  task automatic go();
    bus.enable = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic capture(input int n, input int stop_idx, input int abort_idx,
                         output logic [31:0] pv, output logic [31:0] dv,
                         output logic [31:0] bv);
    pv = '0;
    dv = '0;
    bv = '0;
    for (int i = 0; i < n; i++) begin
      bus.stop  = (i == stop_idx);
      bus.abort = (i == abort_idx);
      pv[i] = bus.pulse_out;
      dv[i] = bus.done;
      bv[i] = bus.busy;
      tick();
    end
    bus.stop  = 1'b0;
    bus.abort = 1'b0;
  endtask

  logic [31:0] pv, dv, bv;
  int          n;

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
    setup(2'd0, 8'd0, 8'd0, 4'd0);
    bus2.enable = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0; bus2.abort = 1'b0;
    bus2.mode = 2'd2; bus2.width = 8'd1; bus2.gap = 8'd0; bus2.count = 2'd0;
    tick();
    tick();
    chk("rst_pulse", bus.pulse_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.pulse_cnt, 0);
    rst_n = 1'b1;
    tick();

    // One-shot, width 5
    setup(2'd0, 8'd5, 8'd0, 4'd0);
    go();
    capture(8, -1, -1, pv, dv, bv);
    chk("os_pulse", pv, 32'h1F);
    chk("os_done", dv, 32'h20);
    chk("os_busy", bv, 32'h3F);
    chk("os_cnt", bus.pulse_cnt, 1);

    // enable low: start ignored
    bus.enable = 1'b0;
    bus.start  = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    chk("en0_busy", bus.busy, 0);

    // start&abort in IDLE: abort wins
    bus.enable = 1'b1;
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 0);

    // start held while busy and in DONE is ignored; accepted the cycle after DONE
    setup(2'd0, 8'd2, 8'd0, 4'd0);
    go();
    chk("rt_p1", bus.pulse_out, 1);
    bus.start = 1'b1;
    tick();
    tick();
    chk("rt_done", bus.done, 1);
    tick();
    chk("rt_idle_after_done", bus.busy, 0);
    tick();
    chk("rt_accept_after_done", bus.pulse_out, 1);
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("rt_end_idle", bus.busy, 0);

    // Burst 3/2/4, inputs scrambled right after accept
    setup(2'd1, 8'd3, 8'd2, 4'd4);
    go();
    setup(2'd0, 8'd7, 8'd5, 4'd1);
    capture(21, -1, -1, pv, dv, bv);
    chk("burst_pulse", pv, 32'h39CE7);
    chk("burst_done", dv, 32'h40000);
    chk("burst_busy", bv, 32'h7FFFF);
    chk("burst_cnt", bus.pulse_cnt, 4);

    // Burst with gap 0: single-cycle gaps
    setup(2'd1, 8'd3, 8'd0, 4'd4);
    go();
    capture(18, -1, -1, pv, dv, bv);
    chk("gap0_pulse", pv, 32'h7777);
    chk("gap0_done", dv, 32'h8000);
    chk("gap0_busy", bv, 32'hFFFF);

    // Continuous 2/2, stop during 3rd HIGH
    setup(2'd2, 8'd2, 8'd2, 4'd0);
    go();
    capture(13, 8, -1, pv, dv, bv);
    chk("cont_stop_pulse", pv, 32'h333);
    chk("cont_stop_done", dv, 32'h400);
    chk("cont_stop_busy", bv, 32'h7FF);
    chk("cont_stop_cnt", bus.pulse_cnt, 3);

    // Burst count 6, abort in 2nd LOW
    setup(2'd1, 8'd2, 8'd2, 4'd6);
    go();
    capture(10, -1, 6, pv, dv, bv);
    chk("abort_pulse", pv, 32'h33);
    chk("abort_done", dv, 32'h0);
    chk("abort_busy", bv, 32'h7F);
    chk("abort_cnt", bus.pulse_cnt, 2);

    // Reset mid-HIGH
    setup(2'd0, 8'd5, 8'd0, 4'd0);
    go();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_pulse", bus.pulse_out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", bus.done, 0);

    // width 0 in every mode
    for (int m = 0; m < 4; m++) begin
      setup(m[1:0], 8'd0, 8'd3, 4'd3);
      go();
      capture(3, -1, -1, pv, dv, bv);
      chk($sformatf("w0_pulse_m%0d", m), pv, 32'h0);
      chk($sformatf("w0_done_m%0d", m), dv, 32'h1);
      chk($sformatf("w0_cnt_m%0d", m), bus.pulse_cnt, 0);
    end

    // Burst with count 0 -> one pulse
    setup(2'd1, 8'd2, 8'd1, 4'd0);
    go();
    capture(5, -1, -1, pv, dv, bv);
    chk("cnt0_pulse", pv, 32'h3);
    chk("cnt0_done", dv, 32'h4);
    chk("cnt0_cnt", bus.pulse_cnt, 1);

    // Maximum width
    setup(2'd0, 8'd255, 8'd0, 4'd0);
    go();
    n = 0;
    while (bus.pulse_out && n < 300) begin
      n++;
      tick();
    end
    chk("wmax_len", n, 255);
    chk("wmax_done", bus.done, 1);
    tick();

    // pulse_cnt wrap on the NW=2 instance: continuous 1/0, stop in 5th HIGH
    bus2.enable = 1'b1;
    bus2.start  = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("wrap_cnt4", bus2.pulse_cnt, 0);
    tick();
    chk("wrap_high5", bus2.pulse_out, 1);
    bus2.stop = 1'b1;
    tick();
    bus2.stop = 1'b0;
    chk("wrap_done", bus2.done, 1);
    chk("wrap_cnt5", bus2.pulse_cnt, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
